// File: rtl/blackjack_pkg.sv
// rtl/blackjack_pkg.sv - shared types and constants for the card dealer
//
// Purpose: dealer FSM state encoding, round result codes, card value range
//          and the per-round card limit, plus a card-range helper.
// Ports:   none (package).
package blackjack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_SETTLE,
    ST_WAIT,
    ST_OVER
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE  = 2'b00,
    RES_WIN   = 2'b01,
    RES_LOSE  = 2'b10,
    RES_SHORT = 2'b11
  } result_e;

  localparam logic [3:0] CARD_MIN  = 4'd1;
  localparam logic [3:0] CARD_MAX  = 4'd9;
  localparam logic [2:0] MAX_CARDS = 3'd4;

  function automatic logic is_card(input logic [3:0] v);
    return (v >= CARD_MIN) && (v <= CARD_MAX);
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// rtl/card_lfsr.sv - free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1
//
// Purpose: pseudo-random source for card values; advances every cycle.
// Ports:   clk  - clock
//          rst  - asynchronous active-low reset, loads seed
//          seed - load value; 0 is replaced by 8'h01 so the register never locks up
//          q    - current LFSR state
module card_lfsr (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic [7:0] load_val;

  always_comb begin
    load_val = (seed == 8'h00) ? 8'h01 : seed;
    // Shift left; feedback from taps 8,6,5,4 (bits 7,5,4,3).
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= load_val;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - deals up to four random cards per round and records the result
//
// Purpose: on each deal request draws a card (1..9) from the LFSR, waits SETTLE
//          cycles, then watches the evaluator's win/lose pulses to close the round.
// Ports:   clk, rst (async active-low)
//          deal_btn              - debounced deal request level, rising edge = request
//          win_pulse, lose_pulse - evaluator flags, honoured only in WAIT
//          first..fourth_card    - dealt values, 0 = not dealt
//          card_count            - cards dealt this round (0..4)
//          busy                  - drawing or settling
//          round_over            - round finished, result valid
//          result                - 00 none, 01 win, 10 lose, 11 short
module card_dealer
  import blackjack_pkg::*;
#(
  parameter logic [7:0]  SEED   = 8'hA5,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_btn,
  input  logic       win_pulse,
  input  logic       lose_pulse,
  output logic [3:0] first_card,
  output logic [3:0] second_card,
  output logic [3:0] third_card,
  output logic [3:0] fourth_card,
  output logic [2:0] card_count,
  output logic       busy,
  output logic       round_over,
  output logic [1:0] result
);

  // Counter is 8 bits wide, so SETTLE up to 256 is supported; 0 behaves as 1.
  localparam logic [7:0] SETTLE_LAST = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

  state_e     state_q, state_d;
  result_e    result_q, result_d;
  logic [3:0] card_q [4];
  logic [3:0] card_d [4];
  logic [2:0] card_count_q, card_count_d;
  logic [7:0] settle_q, settle_d;
  logic       btn_prev_q, btn_prev_d;
  logic       busy_q, busy_d;
  logic       round_over_q, round_over_d;

  logic [7:0] lfsr_q;
  logic       rise;
  logic       unused_lfsr_hi;

  card_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (lfsr_q)
  );

  // Only the low nibble selects a card.
  assign unused_lfsr_hi = ^lfsr_q[7:4];

  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    card_d       = card_q;
    card_count_d = card_count_q;
    settle_d     = settle_q;
    btn_prev_d   = deal_btn;
    rise         = deal_btn & ~btn_prev_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (card_count_q >= MAX_CARDS) begin
          // Unreachable in normal operation; never draw a fifth card.
          state_d = ST_WAIT;
        end else if (is_card(lfsr_q[3:0])) begin
          card_d[card_count_q[1:0]] = lfsr_q[3:0];
          card_count_d              = card_count_q + 3'd1;
          settle_d                  = 8'd0;
          state_d                   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 8'd0;
          state_d  = ST_WAIT;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      ST_WAIT: begin
        if (win_pulse) begin
          result_d = RES_WIN;
          state_d  = ST_OVER;
        end else if (lose_pulse) begin
          result_d = RES_LOSE;
          state_d  = ST_OVER;
        end else if (card_count_q == MAX_CARDS) begin
          result_d = RES_SHORT;
          state_d  = ST_OVER;
        end else if (rise) begin
          state_d = ST_DRAW;
        end
      end
      ST_OVER: begin
        // A new request clears the table and starts drawing on the same edge.
        if (rise) begin
          for (int i = 0; i < 4; i++) card_d[i] = 4'd0;
          card_count_d = 3'd0;
          result_d     = RES_NONE;
          state_d      = ST_DRAW;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status flags follow the next state so they are registered with it.
    busy_d       = (state_d == ST_DRAW) || (state_d == ST_SETTLE);
    round_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      result_q     <= RES_NONE;
      for (int i = 0; i < 4; i++) card_q[i] <= 4'd0;
      card_count_q <= 3'd0;
      settle_q     <= 8'd0;
      btn_prev_q   <= 1'b0;
      busy_q       <= 1'b0;
      round_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      card_q       <= card_d;
      card_count_q <= card_count_d;
      settle_q     <= settle_d;
      btn_prev_q   <= btn_prev_d;
      busy_q       <= busy_d;
      round_over_q <= round_over_d;
    end
  end

  assign first_card  = card_q[0];
  assign second_card = card_q[1];
  assign third_card  = card_q[2];
  assign fourth_card = card_q[3];
  assign card_count  = card_count_q;
  assign busy        = busy_q;
  assign round_over  = round_over_q;
  assign result      = result_q;

endmodule
